// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX path: controller state encoding and the
// edge_cnt points within one bit period that the sampler, checkers and
// controller agree on.
package uart_rx_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // First of the three majority samples (H-2, H-1, H).
  function automatic int unsigned samp_point(input int unsigned prescale);
    return (prescale >> 1) - 2;
  endfunction

  // Checker strobe point, one edge after the last sample.
  function automatic int unsigned chk_point(input int unsigned prescale);
    return (prescale >> 1) + 1;
  endfunction

  // Point where the registered checker results are valid.
  function automatic int unsigned eval_point(input int unsigned prescale);
    return (prescale >> 1) + 2;
  endfunction

  // Bit boundary, where the counter advances bit_cnt.
  function automatic int unsigned last_point(input int unsigned prescale);
    return prescale - 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fsm.sv
// UART RX controller: detects the start edge, enables the edge/bit counter,
// strobes the sampler, deserializer and checkers, and closes each frame with
// a single data_valid, par_err_flag or stp_err_flag pulse.
module uart_rx_ctrl_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
) (
  input  logic             CLK_EDGE,
  input  logic             RST_EDGE,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic [CNT_W-1:0] prescale,
  input  logic [CNT_W-1:0] bit_cnt,
  input  logic [CNT_W-1:0] edge_cnt,
  input  logic             strt_glitch,
  input  logic             par_err,
  input  logic             stp_err,
  output logic             enable_edge,
  output logic             dat_samp_en,
  output logic             deser_en,
  output logic             strt_chk_en,
  output logic             par_chk_en,
  output logic             stp_chk_en,
  output logic             data_valid,
  output logic             par_err_flag,
  output logic             stp_err_flag,
  output logic             busy
);

  rx_state_e        state_q, state_d;
  logic             par_en_q, par_en_d;
  logic             perr_q, perr_d;
  logic             dv_d, pf_d, sf_d;
  logic [CNT_W-1:0] chk_pt, eval_pt, last_pt;
  logic             at_chk, at_eval, at_last, bits_done;

  // Decode the bit-period points from prescale and the current counts.
  always_comb begin
    chk_pt    = CNT_W'(chk_point(32'(prescale)));
    eval_pt   = CNT_W'(eval_point(32'(prescale)));
    last_pt   = CNT_W'(last_point(32'(prescale)));
    at_chk    = (edge_cnt == chk_pt);
    at_eval   = (edge_cnt == eval_pt);
    at_last   = (edge_cnt == last_pt);
    bits_done = (bit_cnt == CNT_W'(DATA_BITS));
  end

  // State, latched frame options and the registered end-of-frame pulses.
  always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
    if (!RST_EDGE) begin
      state_q      <= ST_IDLE;
      par_en_q     <= 1'b0;
      perr_q       <= 1'b0;
      data_valid   <= 1'b0;
      par_err_flag <= 1'b0;
      stp_err_flag <= 1'b0;
    end else begin
      state_q      <= state_d;
      par_en_q     <= par_en_d;
      perr_q       <= perr_d;
      data_valid   <= dv_d;
      par_err_flag <= pf_d;
      stp_err_flag <= sf_d;
    end
  end

  // Next-state logic; the frame verdict is formed on the STOP->IDLE move.
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    perr_d   = perr_q;
    dv_d     = 1'b0;
    pf_d     = 1'b0;
    sf_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!RX_IN) begin
          state_d  = ST_START;
          par_en_d = PAR_EN;
          perr_d   = 1'b0;
        end
      end
      ST_START: begin
        if (at_eval && strt_glitch) begin
          state_d = ST_IDLE;
        end else if (at_last) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_last && bits_done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (at_eval) begin
          perr_d = par_err;
        end
        if (at_last) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        if (at_eval) begin
          state_d = ST_IDLE;
          dv_d    = !perr_q && !stp_err;
          pf_d    = perr_q;
          sf_d    = stp_err && !perr_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational enables and strobes decoded from state and edge_cnt.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    enable_edge = busy;
    dat_samp_en = busy;
    deser_en    = (state_q == ST_DATA)   && at_chk;
    strt_chk_en = (state_q == ST_START)  && at_chk;
    par_chk_en  = (state_q == ST_PARITY) && at_chk;
    stp_chk_en  = (state_q == ST_STOP)   && at_chk;
  end

endmodule
